i2c_target_ip: RTL and testbench

- I2C target (slave) endpoint; the counterpart of the SoC's i2c_master_ip.
- Lets an external I2C controller, or the on-chip master in loopback benches, read and write a byte-addressed register space.
- Access is EEPROM-style: the first written byte sets an internal pointer; subsequent data bytes write or read at the pointer, which auto-increments.
- SCL/SDA are oversampled on the system clock. No clock stretching.

---
 rtl/i2c_target_ip.sv | 252 +++++++++++++++++++++++++
 tb/tb_i2c_target_ip.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_ip.sv
// i2c_target_ip
// I2C target endpoint exposing a byte-addressed register space with
// EEPROM-style access: the first byte written after the address selects an
// internal pointer; further bytes are written at, or read from, the pointer,
// which auto-increments. SCL/SDA are oversampled on clk; no clock stretching.
//
// Handshake note: there is no valid/ready pair here. reg_wr and reg_rd are
// single-clk strobes. reg_wdata/reg_addr are valid while reg_wr is high.
// reg_rdata must reflect reg_addr in the clk where reg_rd is high; it is
// captured at the end of that clk.
//
// Ports
//   clk          system clock, >= 16x SCL
//   reset_n      asynchronous active-low reset
//   scl_i/sda_i  asynchronous pad inputs
//   sda_oe       1 = pull SDA low
//   reg_addr     current pointer
//   reg_wdata    write data (with reg_wr)
//   reg_wr       one-clk write strobe
//   reg_rdata    read data for reg_addr
//   reg_rd       one-clk read-fetch strobe
//   busy         high from address match until STOP / repeated START
//   dbg_state_o  current FSM state (debug)
module i2c_target_ip #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    input  logic [7:0]        reg_rdata,
    output logic              reg_rd,
    output logic              busy,
    output logic [3:0]        dbg_state_o
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT      = 4'd9
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizers plus history FF. Reset to 1 so reset release with idle
    // lines produces no edge.
    // ------------------------------------------------------------------
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det;

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise =  scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s &  scl_hist_q;
    assign sda_rise =  sda_s & ~sda_hist_q;
    assign sda_fall = ~sda_s &  sda_hist_q;
    // SCL must be high in both samples: an SDA edge coinciding with an SCL
    // edge is data, not a bus condition.
    assign start_det = sda_fall & scl_s & scl_hist_q;
    assign stop_det  = sda_rise & scl_s & scl_hist_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;     // receive shifter
    logic [7:0]        tx_q, tx_d;           // transmit shifter
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;

    logic byte_done;
    logic addr_match;
    assign byte_done  = (bit_cnt_q == 4'd8);
    assign addr_match = (shift_q[7:1] == TARGET_ADDR);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR:      if (scl_fall && byte_done) state_d = addr_match ? ADDR_ACK : WAIT;
                // shift_q still holds the address byte; bit 0 is R/W.
                ADDR_ACK:  if (scl_fall) state_d = shift_q[0] ? RDATA : PTR;
                PTR:       if (scl_fall && byte_done) state_d = PTR_ACK;
                PTR_ACK:   if (scl_fall) state_d = WDATA;
                WDATA:     if (scl_fall && byte_done) state_d = WDATA_ACK;
                WDATA_ACK: if (scl_fall) state_d = WDATA;
                RDATA:     if (scl_fall && byte_done) state_d = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && sda_s) state_d = WAIT;
                    else if (scl_fall)     state_d = RDATA;
                end
                default:   state_d = state_q;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;

        // The pointer steps in the clk after the write strobe so reg_addr
        // carries the old pointer while reg_wr is high.
        if (wr_q) ptr_d = ptr_q + ADDR_W'(1);

        if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            if (scl_rise && (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
                shift_d   = {shift_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (state_q)
                ADDR: if (scl_fall && byte_done) begin
                    bit_cnt_d = 4'd0;
                    if (addr_match) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    // Read: keep ACK low one more clk; the load replaces it.
                    if (shift_q[0]) rd_d     = 1'b1;
                    else            sda_oe_d = 1'b0;
                end
                PTR: if (scl_fall && byte_done) begin
                    bit_cnt_d = 4'd0;
                    ptr_d     = ADDR_W'(shift_q);
                    sda_oe_d  = 1'b1;
                end
                WDATA: if (scl_fall && byte_done) begin
                    bit_cnt_d = 4'd0;
                    wdata_d   = shift_q;
                    wr_d      = 1'b1;
                    sda_oe_d  = 1'b1;
                end
                PTR_ACK, WDATA_ACK: if (scl_fall) sda_oe_d = 1'b0;
                RDATA: begin
                    if (rd_q) begin
                        // reg_rdata is valid for the address fetched last clk.
                        tx_d      = reg_rdata;
                        sda_oe_d  = ~reg_rdata[7];
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            tx_d      = {tx_q[6:0], 1'b0};
                            sda_oe_d  = ~tx_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && !sda_s) ptr_d = ptr_q + ADDR_W'(1);
                    if (scl_fall)           rd_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            tx_q      <= 8'd0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wdata_q   <= 8'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign reg_addr    = ptr_q;
    assign reg_wdata   = wdata_q;
    assign reg_wr      = wr_q;
    assign reg_rd      = rd_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_target_ip.sv
module tb_i2c_target_ip;
    localparam int         Q       = 8;      // clks per SCL quarter period
    localparam logic [7:0] WR_ADDR = 8'h84;
    localparam logic [7:0] RD_ADDR = 8'h85;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       scl_m, sda_m;
    logic       scl_i, sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, reg_rd, busy;
    logic [3:0] dbg_state;

    // Open-drain bus: either side may pull SDA low.
    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    int rdata_mode;
    function automatic logic [7:0] rdata_fn(input int mode, input logic [7:0] a);
        if (mode == 0) return 8'hC0 | {4'h0, a[3:0]};
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction
    always_comb reg_rdata = rdata_fn(rdata_mode, reg_addr);

    i2c_target_ip #(.TARGET_ADDR(7'h42), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .scl_i(scl_i), .sda_i(sda_i),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wr(reg_wr), .reg_rdata(reg_rdata), .reg_rd(reg_rd),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    // ---------------- monitor / scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] obs_wr_q[$];
    int          rd_cnt;
    bit          oe_seen, busy_seen;
    logic [7:0]  model_ptr;
    int          n_checks, n_fail;

    always @(negedge clk) begin
        if (reg_wr) obs_wr_q.push_back({reg_addr, reg_wdata});
        if (reg_rd) rd_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (busy)   busy_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        b = sda_i;    wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_bits8(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
    endtask

    task automatic drv_write_txn(input logic [7:0] ptr, input logic [7:0] d[$], output int nacks);
        logic a;
        nacks = 0;
        bus_start();
        send_byte(WR_ADDR, a); nacks += int'(a);
        send_byte(ptr, a);     nacks += int'(a);
        foreach (d[i]) begin
            send_byte(d[i], a); nacks += int'(a);
        end
        bus_stop();
    endtask

    // Reads n bytes (ACK all but the last). Optionally sets the pointer first
    // with a write header followed by a repeated START.
    task automatic drv_read_txn(input bit set_ptr, input logic [7:0] ptr, input int n,
                                output logic [7:0] got[$], output int nacks, output logic last_oe);
        logic a;
        logic [7:0] b;
        nacks = 0;
        got.delete();
        last_oe = 1'b0;
        bus_start();
        if (set_ptr) begin
            send_byte(WR_ADDR, a); nacks += int'(a);
            send_byte(ptr, a);     nacks += int'(a);
            bus_start();
        end
        send_byte(RD_ADDR, a); nacks += int'(a);
        for (int i = 0; i < n; i++) begin
            recv_bits8(b);
            got.push_back(b);
            if (i == n - 1) last_oe = sda_oe;
            send_bit(i == n - 1);
        end
        bus_stop();
    endtask

    task automatic clear_obs();
        obs_wr_q.delete();
        exp_q.delete();
        rd_cnt    = 0;
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++; if (sda_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_checks++; if (reg_wr !== 1'b0)    begin n_fail++; $display("FAIL reset_reg_wr: got %b want 0", reg_wr); end
        n_checks++; if (reg_rd !== 1'b0)    begin n_fail++; $display("FAIL reset_reg_rd: got %b want 0", reg_rd); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (reg_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
        n_checks++; if (reg_addr !== 8'h0)  begin n_fail++; $display("FAIL reset_ptr: got %h want 00", reg_addr); end
        n_checks++; if (dbg_state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_write();
        logic a;
        clear_obs();
        bus_start();
        send_byte(WR_ADDR, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 0", a); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
        send_byte(8'h10, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_ptr_ack: got %b want 0", a); end
        send_byte(8'hA5, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_d0_ack: got %b want 0", a); end
        send_byte(8'h5A, a);
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wr_d1_ack: got %b want 0", a); end
        bus_stop();
        wait_clks(4);
        exp_q.push_back({8'h10, 8'hA5});
        exp_q.push_back({8'h11, 8'h5A});
        model_ptr = 8'h12;
        n_checks++; if (obs_wr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wr_count: got %0d want %0d", obs_wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_wr_q.size(); i++) begin
            n_checks++; if (obs_wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wr_item%0d: got %h want %h", i, obs_wr_q[i], exp_q[i]); end
        end
        n_checks++; if (reg_addr !== model_ptr) begin n_fail++; $display("FAIL wr_ptr_end: got %h want %h", reg_addr, model_ptr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_combined_read();
        logic [7:0] got[$];
        int nacks;
        logic last_oe;
        clear_obs();
        rdata_mode = 0;
        drv_read_txn(1'b1, 8'h20, 2, got, nacks, last_oe);
        wait_clks(4);
        model_ptr = 8'h21;
        n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL rd_acks: got %0d nacks want 0", nacks); end
        n_checks++; if (got[0] !== 8'hC0) begin n_fail++; $display("FAIL rd_byte0: got %h want c0", got[0]); end
        n_checks++; if (got[1] !== 8'hC1) begin n_fail++; $display("FAIL rd_byte1: got %h want c1", got[1]); end
        n_checks++; if (rd_cnt !== 2) begin n_fail++; $display("FAIL rd_strobes: got %0d want 2", rd_cnt); end
        n_checks++; if (obs_wr_q.size() !== 0) begin n_fail++; $display("FAIL rd_no_wr: got %0d writes want 0", obs_wr_q.size()); end
        n_checks++; if (last_oe !== 1'b0) begin n_fail++; $display("FAIL rd_release: got sda_oe=%b want 0", last_oe); end
        n_checks++; if (reg_addr !== model_ptr) begin n_fail++; $display("FAIL rd_ptr_end: got %h want %h", reg_addr, model_ptr); end
    endtask

    task automatic test_wrong_addr();
        logic a;
        logic [6:0] bad;
        logic [7:0] d[$];
        int nacks;
        clear_obs();
        do bad = 7'($urandom_range(0, 127)); while (bad == 7'h42);
        bus_start();
        send_byte({bad, 1'($urandom_range(0, 1))}, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL bad_addr_nack: addr %h got ack=%b want 1", bad, a); end
        send_byte(8'($urandom_range(0, 255)), a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL bad_addr_data_nack: got ack=%b want 1", a); end
        bus_stop();
        wait_clks(4);
        n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL bad_addr_sda: got pulled=%b want 0", oe_seen); end
        n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL bad_addr_busy: got %b want 0", busy_seen); end
        n_checks++; if (obs_wr_q.size() + rd_cnt !== 0) begin n_fail++; $display("FAIL bad_addr_strobes: got %0d want 0", obs_wr_q.size() + rd_cnt); end
        // A correct transfer right after must work.
        clear_obs();
        d.push_back(8'h6C);
        drv_write_txn(8'h40, d, nacks);
        wait_clks(4);
        model_ptr = 8'h41;
        n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL good_after_bad_acks: got %0d nacks want 0", nacks); end
        n_checks++; if (obs_wr_q.size() !== 1 || obs_wr_q[0] !== 16'h406C) begin n_fail++; $display("FAIL good_after_bad_wr: got %0d writes want 1 of 406c", obs_wr_q.size()); end
    endtask

    task automatic test_ptr_wrap();
        logic [7:0] d[$];
        int nacks;
        clear_obs();
        d.push_back(8'h11);
        d.push_back(8'h22);
        drv_write_txn(8'hFF, d, nacks);
        wait_clks(4);
        exp_q.push_back({8'hFF, 8'h11});
        exp_q.push_back({8'h00, 8'h22});
        model_ptr = 8'h01;
        n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL wrap_acks: got %0d nacks want 0", nacks); end
        n_checks++; if (obs_wr_q.size() !== 2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", obs_wr_q.size()); end
        for (int i = 0; i < 2 && i < obs_wr_q.size(); i++) begin
            n_checks++; if (obs_wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_item%0d: got %h want %h", i, obs_wr_q[i], exp_q[i]); end
        end
        n_checks++; if (reg_addr !== model_ptr) begin n_fail++; $display("FAIL wrap_ptr_end: got %h want %h", reg_addr, model_ptr); end
    endtask

    task automatic test_abort();
        logic a;
        logic [7:0] p;
        clear_obs();
        p = 8'($urandom_range(0, 255));
        bus_start();
        send_byte(WR_ADDR, a);
        send_byte(p, a);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        bus_stop();
        wait_clks(4);
        model_ptr = p;
        n_checks++; if (obs_wr_q.size() !== 0) begin n_fail++; $display("FAIL abort_no_wr: got %0d writes want 0", obs_wr_q.size()); end
        n_checks++; if (dbg_state !== 4'd0) begin n_fail++; $display("FAIL abort_state: got %0d want 0", dbg_state); end
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL abort_sda_oe: got %b want 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (reg_addr !== model_ptr) begin n_fail++; $display("FAIL abort_ptr: got %h want %h", reg_addr, model_ptr); end
    endtask

    task automatic test_random();
        logic [7:0] d[$];
        logic [7:0] got[$];
        logic [7:0] p, start_ptr, want;
        int nacks, n;
        bit set_ptr;
        logic last_oe;
        for (int it = 0; it < 8; it++) begin
            clear_obs();
            if ($urandom_range(0, 1) == 0) begin
                d.delete();
                p = 8'($urandom_range(0, 255));
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) begin
                    d.push_back(8'($urandom_range(0, 255)));
                    exp_q.push_back({8'(p + 8'(i)), d[i]});
                end
                drv_write_txn(p, d, nacks);
                wait_clks(4);
                model_ptr = 8'(p + 8'(n));
                n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL rnd%0d_wr_acks: got %0d want 0", it, nacks); end
                n_checks++; if (obs_wr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", it, obs_wr_q.size(), exp_q.size()); end
                for (int i = 0; i < exp_q.size() && i < obs_wr_q.size(); i++) begin
                    n_checks++; if (obs_wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_wr_item%0d: got %h want %h", it, i, obs_wr_q[i], exp_q[i]); end
                end
            end else begin
                rdata_mode = $urandom_range(0, 1);
                set_ptr    = 1'($urandom_range(0, 1));
                p          = 8'($urandom_range(0, 255));
                n          = $urandom_range(1, 3);
                start_ptr  = set_ptr ? p : model_ptr;
                drv_read_txn(set_ptr, p, n, got, nacks, last_oe);
                wait_clks(4);
                n_checks++; if (nacks !== 0) begin n_fail++; $display("FAIL rnd%0d_rd_acks: got %0d want 0", it, nacks); end
                n_checks++; if (rd_cnt !== n) begin n_fail++; $display("FAIL rnd%0d_rd_strobes: got %0d want %0d", it, rd_cnt, n); end
                for (int i = 0; i < n; i++) begin
                    want = rdata_fn(rdata_mode, 8'(start_ptr + 8'(i)));
                    n_checks++; if (got[i] !== want) begin n_fail++; $display("FAIL rnd%0d_rd_byte%0d: got %h want %h", it, i, got[i], want); end
                end
                model_ptr = 8'(start_ptr + 8'(n - 1));
            end
            n_checks++; if (reg_addr !== model_ptr) begin n_fail++; $display("FAIL rnd%0d_ptr: got %h want %h", it, reg_addr, model_ptr); end
        end
    endtask

    task automatic test_reset_midread();
        logic a, b;
        logic [7:0] got[$];
        int nacks;
        logic last_oe;
        rdata_mode = 0;
        bus_start();
        send_byte(WR_ADDR, a);
        send_byte(8'h37, a);
        bus_start();
        send_byte(RD_ADDR, a);
        // Byte at 0x37 is 0xC7: third bit is 0, so the target is pulling now.
        recv_bit(b);
        recv_bit(b);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_oe: got %b want 1", sda_oe); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_oe: got %b want 0", sda_oe); end
        n_checks++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL rst_ptr: got %h want 00", reg_addr); end
        model_ptr = 8'h00;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clks(4);
        reset_n = 1'b1;
        clear_obs();
        wait_clks(20);
        n_checks++; if (dbg_state !== 4'd0) begin n_fail++; $display("FAIL rst_no_false_start: state %0d want 0", dbg_state); end
        n_checks++; if (rd_cnt + obs_wr_q.size() !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_quiet: strobes %0d busy %b want 0/0", rd_cnt + obs_wr_q.size(), busy); end
        drv_read_txn(1'b0, 8'h00, 1, got, nacks, last_oe);
        n_checks++; if (nacks !== 0 || got[0] !== rdata_fn(0, model_ptr)) begin n_fail++; $display("FAIL rst_read_after: got %h nacks %0d want %h/0", got[0], nacks, rdata_fn(0, model_ptr)); end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rdata_mode = 0;
        model_ptr  = 8'h00;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        reset_n    = 1'b0;
        clear_obs();
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(5);
        test_reset();
        test_write();
        test_combined_read();
        test_wrong_addr();
        test_ptr_wrap();
        test_abort();
        test_random();
        test_reset_midread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
